sid_envelope: RTL and testbench

- One SID voice ADSR envelope generator, clocked by the system clock and advanced by a one-cycle-per-SID-cycle `tick` enable.
- Produces the 8-bit envelope level consumed directly by the 8-bit envelope DAC (sid_dac, BITS=8, 2R/R=2.20, no termination) ahead of the voice amplitude multiply.
- Implements the 15-bit rate counter, the piecewise exponential decay divider and the ADSR state machine with SID-exact rate periods.

---
 rtl/sid_envelope.sv | 143 ++++++++++++++
 tb/tb_sid_envelope.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sid_envelope.sv
// rtl/sid_envelope.sv - SID voice ADSR envelope generator with SID-exact rate periods
module sid_envelope #(
    parameter int RATE_BITS = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       gate,
    input  logic [3:0] attack,
    input  logic [3:0] decay,
    input  logic [3:0] sustain,
    input  logic [3:0] release_rate,
    output logic [7:0] env,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_ATTACK        = 2'd0,
        ST_DECAY_SUSTAIN = 2'd1,
        ST_RELEASE       = 2'd2
    } env_state_t;

    env_state_t           state_q, state_d, edge_state;
    logic [RATE_BITS-1:0] rate_cnt_q, rate_cnt_d, rate_nxt, period;
    logic [4:0]           exp_cnt_q, exp_cnt_d, exp_inc, exp_period;
    logic [7:0]           env_q, env_d, env_step;
    logic                 hold_zero_q, hold_zero_d;
    logic                 gate_q, gate_d;
    logic [3:0]           rate;
    logic                 gate_rise, gate_fall, rate_step;

    function automatic logic [14:0] rate_period(input logic [3:0] idx);
        case (idx)
            4'd0:    rate_period = 15'd9;
            4'd1:    rate_period = 15'd32;
            4'd2:    rate_period = 15'd63;
            4'd3:    rate_period = 15'd95;
            4'd4:    rate_period = 15'd149;
            4'd5:    rate_period = 15'd220;
            4'd6:    rate_period = 15'd267;
            4'd7:    rate_period = 15'd313;
            4'd8:    rate_period = 15'd392;
            4'd9:    rate_period = 15'd977;
            4'd10:   rate_period = 15'd1954;
            4'd11:   rate_period = 15'd3126;
            4'd12:   rate_period = 15'd3907;
            4'd13:   rate_period = 15'd11720;
            4'd14:   rate_period = 15'd19532;
            default: rate_period = 15'd31251;
        endcase
    endfunction

    // Piecewise approximation of an exponential decay curve.
    function automatic logic [4:0] exp_div(input logic [7:0] level);
        if (level >= 8'h5e)      exp_div = 5'd1;
        else if (level >= 8'h37) exp_div = 5'd2;
        else if (level >= 8'h1b) exp_div = 5'd4;
        else if (level >= 8'h0f) exp_div = 5'd8;
        else if (level >= 8'h07) exp_div = 5'd16;
        else if (level >= 8'h01) exp_div = 5'd30;
        else                     exp_div = 5'd1;
    endfunction

    always_comb begin
        gate_rise = gate & ~gate_q;
        gate_fall = ~gate & gate_q;
        if (gate_rise)      edge_state = ST_ATTACK;
        else if (gate_fall) edge_state = ST_RELEASE;
        else                edge_state = state_q;

        case (edge_state)
            ST_ATTACK:        rate = attack;
            ST_DECAY_SUSTAIN: rate = decay;
            default:          rate = release_rate;
        endcase

        period     = RATE_BITS'(rate_period(rate));
        // No clamp: a lowered period lets the counter run past it and wrap.
        rate_nxt   = rate_cnt_q + 1'b1;
        rate_step  = (rate_nxt == period);
        exp_period = exp_div(env_q);
        exp_inc    = exp_cnt_q + 5'd1;

        env_step = env_q;
        if (!hold_zero_q &&
            !(edge_state == ST_DECAY_SUSTAIN && env_q == {sustain, sustain}))
            env_step = env_q - 8'd1;
    end

    always_comb begin
        state_d     = state_q;
        rate_cnt_d  = rate_cnt_q;
        exp_cnt_d   = exp_cnt_q;
        env_d       = env_q;
        hold_zero_d = hold_zero_q;
        gate_d      = gate_q;
        if (tick) begin
            gate_d     = gate;
            state_d    = edge_state;
            rate_cnt_d = rate_step ? '0 : rate_nxt;
            if (gate_rise)
                hold_zero_d = 1'b0;
            if (rate_step) begin
                if (edge_state == ST_ATTACK) begin
                    exp_cnt_d = '0;
                    if (env_q != 8'hff)
                        env_d = env_q + 8'd1;
                    if (env_q == 8'hfe)
                        state_d = ST_DECAY_SUSTAIN;
                end else if (exp_inc == exp_period) begin
                    exp_cnt_d = '0;
                    env_d     = env_step;
                    if (env_step == 8'h00)
                        hold_zero_d = 1'b1;
                end else begin
                    exp_cnt_d = exp_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RELEASE;
            rate_cnt_q  <= '0;
            exp_cnt_q   <= '0;
            env_q       <= 8'h00;
            hold_zero_q <= 1'b1;
            gate_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rate_cnt_q  <= rate_cnt_d;
            exp_cnt_q   <= exp_cnt_d;
            env_q       <= env_d;
            hold_zero_q <= hold_zero_d;
            gate_q      <= gate_d;
        end
    end

    assign env   = env_q;
    assign state = state_q;

endmodule

// File: tb/tb_sid_envelope.sv
// tb/tb_sid_envelope.sv - randomized and directed check of sid_envelope against a behavioural model
module tb_sid_envelope;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       gate = 1'b0;
    logic [3:0] attack = 4'd0;
    logic [3:0] decay = 4'd0;
    logic [3:0] sustain = 4'd8;
    logic [3:0] release_rate = 4'd0;
    logic [7:0] env;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;
    int cycle = 0;
    bit chk_en = 1'b0;

    int m_env = 0, m_state = 2, m_rc = 0, m_ec = 0;
    bit m_hz = 1'b1, m_gq = 1'b0;
    int periods[16] = '{9, 32, 63, 95, 149, 220, 267, 313, 392,
                        977, 1954, 3126, 3907, 11720, 19532, 31251};

    sid_envelope #(.RATE_BITS(15)) dut (
        .clk(clk), .rst(rst), .tick(tick), .gate(gate),
        .attack(attack), .decay(decay), .sustain(sustain),
        .release_rate(release_rate), .env(env), .state(state)
    );

    always #5 clk = ~clk;

    function automatic int exp_period(input int lvl);
        if (lvl >= 94) return 1;
        if (lvl >= 55) return 2;
        if (lvl >= 27) return 4;
        if (lvl >= 15) return 8;
        if (lvl >= 7)  return 16;
        if (lvl >= 1)  return 30;
        return 1;
    endfunction

    task automatic model_tick();
        int r;
        if (gate && !m_gq) begin
            m_state = 0;
            m_hz = 1'b0;
        end else if (!gate && m_gq) begin
            m_state = 2;
        end
        m_gq = gate;
        r = (m_state == 0) ? int'(attack) : (m_state == 1) ? int'(decay) : int'(release_rate);
        m_rc = (m_rc + 1) % 32768;
        if (m_rc == periods[r]) begin
            m_rc = 0;
            if (m_state == 0) begin
                m_ec = 0;
                if (m_env == 254) m_state = 1;
                if (m_env < 255) m_env = m_env + 1;
            end else begin
                m_ec = m_ec + 1;
                if (m_ec == exp_period(m_env)) begin
                    m_ec = 0;
                    if (!m_hz && !(m_state == 1 && m_env == 17 * int'(sustain)))
                        m_env = (m_env + 255) % 256;
                    if (m_env == 0) m_hz = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        cycle++;
        if (rst) begin
            m_env = 0; m_state = 2; m_rc = 0; m_ec = 0; m_hz = 1'b1; m_gq = 1'b0;
        end else if (tick) begin
            model_tick();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (env !== 8'(m_env) || state !== 2'(m_state)) begin
                n_err++;
                $display("FAIL cycle %0d env/state: dut env=%h state=%0d, model env=%h state=%0d",
                         cycle, env, state, m_env, m_state);
            end
        end
    end

    task automatic check_lit(input string name, input logic [7:0] dut_v, input int mdl_v,
                             input int want);
        n_vec++;
        if (dut_v !== 8'(want)) begin
            n_err++;
            $display("FAIL %s: dut=%h required=%h", name, dut_v, want);
        end
        n_vec++;
        if (mdl_v != want) begin
            n_err++;
            $display("FAIL %s(model): model=%h required=%h", name, mdl_v, want);
        end
    endtask

    task automatic run(input int n);
        tick = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    function automatic logic [3:0] pick_rate();
        if ($urandom_range(7) == 0) return 4'($urandom_range(15));
        return 4'($urandom_range(2));
    endfunction

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_lit("reset_env", env, m_env, 8'h00);
        check_lit("reset_state", {6'd0, state}, m_state, 2);

        gate = 1'b1;
        run(2294);
        check_lit("attack_fe", env, m_env, 8'hfe);
        check_lit("attack_fe_state", {6'd0, state}, m_state, 0);
        run(1);
        check_lit("attack_ff", env, m_env, 8'hff);
        check_lit("attack_ff_state", {6'd0, state}, m_state, 1);

        run(1070);
        check_lit("decay_89", env, m_env, 8'h89);
        run(1);
        check_lit("decay_88", env, m_env, 8'h88);
        run(504);
        check_lit("sustain_hold", env, m_env, 8'h88);

        gate = 1'b0;
        run(5732);
        check_lit("release_01", env, m_env, 8'h01);
        run(1);
        check_lit("release_00", env, m_env, 8'h00);
        run(2997);
        check_lit("release_hold", env, m_env, 8'h00);

        gate = 1'b1;
        run(720);
        check_lit("reattack_50", env, m_env, 8'h50);
        gate = 1'b0;
        run(288);
        check_lit("release_40", env, m_env, 8'h40);
        gate = 1'b1;
        run(1);
        check_lit("retrig_state", {6'd0, state}, m_state, 0);
        check_lit("retrig_env", env, m_env, 8'h40);
        run(8);
        check_lit("retrig_inc", env, m_env, 8'h41);

        attack = 4'hf;
        run(20000);
        check_lit("slow_attack", env, m_env, 8'h41);
        attack = 4'h0;
        run(12776);
        check_lit("bug_no_step", env, m_env, 8'h41);
        run(1);
        check_lit("bug_step", env, m_env, 8'h42);
        attack = 4'hf;
        run(5);
        attack = 4'h0;
        run(4);
        check_lit("ctrl_step", env, m_env, 8'h43);

        for (int i = 0; i < 1000; i++) begin
            if (i % 7 == 0) gate = ~gate;
            @(posedge clk); #1;
        end
        gate = 1'b1;
        check_lit("notick_env", env, m_env, 8'h43);
        check_lit("notick_state", {6'd0, state}, m_state, 0);

        run(30);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_lit("midrst_env", env, m_env, 8'h00);
        check_lit("midrst_state", {6'd0, state}, m_state, 2);

        for (int c = 0; c < 25000; c++) begin
            tick = ($urandom_range(3) != 0);
            if ($urandom_range(599) == 0) gate = ~gate;
            if ($urandom_range(199) == 0) attack = pick_rate();
            if ($urandom_range(199) == 0) decay = pick_rate();
            if ($urandom_range(199) == 0) release_rate = pick_rate();
            if ($urandom_range(299) == 0) sustain = 4'($urandom_range(15));
            rst = ($urandom_range(4999) == 0);
            @(posedge clk); #1;
        end
        tick = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
